// File: rtl/mem_bus_responder.sv
// mem_bus_responder: memory-side responder for CPU control-word requests.
// Applies per-region wait states, stalls the CPU while busy, drives a
// synchronous backing store and returns size-aligned read data.
module mem_bus_responder #(
  parameter int unsigned BIOS_WAIT  = 0,
  parameter int unsigned EWRAM_WAIT = 2,
  parameter int unsigned ROM_N_WAIT = 4,
  parameter int unsigned ROM_S_WAIT = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_read_en,
  input  logic        req_write_en,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic [1:0]  req_size,
  input  logic        req_seq,
  output logic        cpu_wait,
  output logic        rsp_valid,
  output logic [31:0] rsp_rdata,
  output logic        mem_en,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [3:0]  mem_be,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata
);

  // Counter only ever holds W-1, so it is sized from the largest wait value.
  localparam int unsigned MAXW_A = (BIOS_WAIT > EWRAM_WAIT) ? BIOS_WAIT : EWRAM_WAIT;
  localparam int unsigned MAXW_B = (ROM_N_WAIT > ROM_S_WAIT) ? ROM_N_WAIT : ROM_S_WAIT;
  localparam int unsigned MAXW   = (MAXW_A > MAXW_B) ? MAXW_A : MAXW_B;
  localparam int unsigned CW     = (MAXW < 2) ? 1 : $clog2(MAXW);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_WAIT   = 2'd1,
    S_ACCESS = 2'd2,
    S_RESP   = 2'd3
  } state_t;

  state_t        r_state;
  state_t        w_next;
  logic [CW-1:0] r_cnt;
  logic [31:0]   r_addr;
  logic [1:0]    r_size;
  logic          r_wr;
  logic          r_mapped;
  logic [3:0]    r_be;
  logic [31:0]   r_wdata;
  logic [31:0]   r_rdata;

  logic          w_req;
  logic [31:0]   w_wait;
  logic          w_mapped;
  logic [3:0]    w_be;
  logic [31:0]   w_wdata;
  logic [31:0]   w_fmt;
  logic          w_rd_upd;

  assign w_req = req_read_en | req_write_en;

  // Region decode on address bits [27:24] gives the wait count and mapping.
  always_comb begin
    w_wait   = 32'd0;
    w_mapped = 1'b1;
    case (req_addr[27:24])
      4'h0:                      w_wait = BIOS_WAIT;
      4'h2:                      w_wait = EWRAM_WAIT;
      4'h3, 4'h4:                w_wait = 32'd0;
      4'h8, 4'h9, 4'hA, 4'hB,
      4'hC, 4'hD:                w_wait = req_seq ? ROM_S_WAIT : ROM_N_WAIT;
      default:                   w_mapped = 1'b0;
    endcase
  end

  // Byte-lane enables and lane-replicated write data, computed at accept time.
  always_comb begin
    w_be    = 4'hF;
    w_wdata = req_wdata;
    case (req_size)
      2'd0: begin
        w_be    = 4'b0001 << req_addr[1:0];
        w_wdata = {4{req_wdata[7:0]}};
      end
      2'd1: begin
        w_be    = 4'b0011 << {req_addr[1], 1'b0};
        w_wdata = {2{req_wdata[15:0]}};
      end
      default: begin
        w_be    = 4'hF;
        w_wdata = req_wdata;
      end
    endcase
  end

  // Read formatting: zero-extended lane/half, or ARM rotate for words.
  always_comb begin
    w_fmt = mem_rdata;
    case (r_size)
      2'd0: begin
        case (r_addr[1:0])
          2'd0:    w_fmt = {24'd0, mem_rdata[7:0]};
          2'd1:    w_fmt = {24'd0, mem_rdata[15:8]};
          2'd2:    w_fmt = {24'd0, mem_rdata[23:16]};
          default: w_fmt = {24'd0, mem_rdata[31:24]};
        endcase
      end
      2'd1: w_fmt = r_addr[1] ? {16'd0, mem_rdata[31:16]} : {16'd0, mem_rdata[15:0]};
      default: begin
        case (r_addr[1:0])
          2'd0:    w_fmt = mem_rdata;
          2'd1:    w_fmt = {mem_rdata[7:0],  mem_rdata[31:8]};
          2'd2:    w_fmt = {mem_rdata[15:0], mem_rdata[31:16]};
          default: w_fmt = {mem_rdata[23:0], mem_rdata[31:24]};
        endcase
      end
    endcase
  end

  // Only mapped reads refresh the result; writes and open-bus reads hold it.
  assign w_rd_upd = (r_state == S_RESP) && !r_wr && r_mapped;

  // State register, wait counter and request latch.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= S_IDLE;
      r_cnt    <= '0;
      r_addr   <= '0;
      r_size   <= '0;
      r_wr     <= 1'b0;
      r_mapped <= 1'b0;
      r_be     <= '0;
      r_wdata  <= '0;
      r_rdata  <= '0;
    end else begin
      r_state <= w_next;
      if (r_state == S_IDLE && w_req) begin
        r_addr   <= req_addr;
        r_size   <= req_size;
        r_wr     <= req_write_en;
        r_mapped <= w_mapped;
        r_be     <= w_be;
        r_wdata  <= w_wdata;
        if (w_wait != 32'd0) r_cnt <= CW'(w_wait - 32'd1);
      end else if (r_state == S_WAIT && r_cnt != '0) begin
        r_cnt <= r_cnt - 1'b1;
      end
      if (w_rd_upd) r_rdata <= w_fmt;
    end
  end

  // Next-state logic and bus outputs.
  always_comb begin
    w_next    = r_state;
    cpu_wait  = 1'b0;
    rsp_valid = 1'b0;
    mem_en    = 1'b0;
    mem_we    = 1'b0;
    mem_be    = 4'h0;
    case (r_state)
      S_IDLE: begin
        if (w_req) begin
          cpu_wait = 1'b1;
          w_next   = (w_wait != 32'd0) ? S_WAIT : S_ACCESS;
        end
      end
      S_WAIT: begin
        cpu_wait = 1'b1;
        if (r_cnt == '0) w_next = S_ACCESS;
      end
      S_ACCESS: begin
        cpu_wait = 1'b1;
        mem_en   = r_mapped;
        mem_we   = r_mapped & r_wr;
        mem_be   = r_mapped ? r_be : 4'h0;
        w_next   = S_RESP;
      end
      default: begin
        rsp_valid = 1'b1;
        w_next    = S_IDLE;
      end
    endcase
    // Keep the stall low while reset is held even if a request is present.
    if (!rst_n) cpu_wait = 1'b0;
  end

  assign mem_addr  = {r_addr[31:2], 2'b00};
  assign mem_wdata = r_wdata;
  // Result is live in RESP so the CPU can take it at that edge, held after.
  assign rsp_rdata = w_rd_upd ? w_fmt : r_rdata;

endmodule

// File: tb/tb_mem_bus_responder.sv
// Scoreboard bench for mem_bus_responder.
module tb_mem_bus_responder;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_read_en, req_write_en, req_seq;
  logic [31:0] req_addr, req_wdata;
  logic [1:0]  req_size;
  logic        cpu_wait, rsp_valid, mem_en, mem_we;
  logic [31:0] rsp_rdata, mem_addr, mem_wdata;
  logic [3:0]  mem_be;
  logic [31:0] mem_rdata = 32'd0;

  mem_bus_responder dut (
    .clk(clk), .rst_n(rst_n),
    .req_read_en(req_read_en), .req_write_en(req_write_en),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_size(req_size),
    .req_seq(req_seq), .cpu_wait(cpu_wait), .rsp_valid(rsp_valid),
    .rsp_rdata(rsp_rdata), .mem_en(mem_en), .mem_we(mem_we),
    .mem_addr(mem_addr), .mem_be(mem_be), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] addr;  logic [1:0] size;
    logic rd, wr, seq;
    logic [31:0] wdata, store;
    int lat;
    logic [31:0] rdata;
    logic mapped;
    logic [3:0] be;
    logic [31:0] mwdata;
  } txn_t;

  typedef struct { logic [31:0] rdata; int t0; int lat; } rsp_exp_t;
  typedef struct { logic we; logic [3:0] be; logic [31:0] addr, wdata; } mem_exp_t;

  rsp_exp_t    rq[$];
  mem_exp_t    mq[$];
  int          n_chk = 0, n_err = 0, cyc = 0;
  logic [31:0] cur_store = 32'd0;
  logic [31:0] last_rd = 32'd0;
  txn_t        tbl[14];

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  function automatic txn_t mk(logic [31:0] a, logic [1:0] sz, logic rd, logic wr, logic sq,
                              logic [31:0] wd, logic [31:0] st, int lat, logic [31:0] rdat,
                              logic mp, logic [3:0] be, logic [31:0] mwd);
    txn_t t;
    t.addr = a; t.size = sz; t.rd = rd; t.wr = wr; t.seq = sq; t.wdata = wd;
    t.store = st; t.lat = lat; t.rdata = rdat; t.mapped = mp; t.be = be; t.mwdata = mwd;
    return t;
  endfunction

  always @(posedge clk) cyc <= cyc + 1;

  // Backing store: returns the programmed word the cycle after a read strobe.
  always @(posedge clk) if (mem_en && !mem_we) mem_rdata <= cur_store;

  // Monitor: pops expectations as the DUT produces bus and response activity.
  always @(negedge clk) begin
    if (rst_n) begin
      if (mem_en) begin
        if (mq.size() == 0) chk("unexp_mem_en", 32'(mem_en), 32'd0);
        else begin
          mem_exp_t m;
          m = mq.pop_front();
          chk("mem_we", 32'(mem_we), 32'(m.we));
          chk("mem_be", 32'(mem_be), 32'(m.be));
          chk("mem_addr", mem_addr, m.addr);
          chk("mem_wdata", mem_wdata, m.wdata);
        end
      end
      if (rsp_valid) begin
        if (rq.size() == 0) chk("unexp_rsp", 32'(rsp_valid), 32'd0);
        else begin
          rsp_exp_t r;
          r = rq.pop_front();
          chk("rsp_rdata", rsp_rdata, r.rdata);
          chk("latency", 32'(cyc - r.t0), 32'(r.lat));
        end
      end
    end
  end

  // Drive one request (called just after a rising edge) and hold it to RESP.
  task automatic run(input txn_t t);
    int  nw = 0;
    bit  got = 0;
    rsp_exp_t r;
    mem_exp_t m;
    req_addr = t.addr; req_size = t.size; req_read_en = t.rd; req_write_en = t.wr;
    req_seq = t.seq; req_wdata = t.wdata; cur_store = t.store;
    if (t.rd && !t.wr && t.mapped) last_rd = t.rdata;
    r.rdata = last_rd; r.t0 = cyc; r.lat = t.lat;
    rq.push_back(r);
    if (t.mapped) begin
      m.we = t.wr; m.be = t.be; m.addr = {t.addr[31:2], 2'b00}; m.wdata = t.mwdata;
      mq.push_back(m);
    end
    for (int i = 0; i < 20 && !got; i++) begin
      @(negedge clk);
      if (rsp_valid) got = 1;
      else if (cpu_wait) nw++;
    end
    if (!got) chk("timeout", 32'd0, 32'd1);
    chk("wait_in_resp", 32'(cpu_wait), 32'd0);
    chk("wait_cycles", 32'(nw), 32'(t.lat));
    @(posedge clk); #1;
  endtask

  initial begin
    tbl[0]  = mk(32'h0300_0010, 2'd2, 1, 0, 0, 32'h0,         32'h1122_3344, 2, 32'h1122_3344, 1, 4'hF, 32'h0);
    tbl[1]  = mk(32'h0200_0000, 2'd2, 1, 0, 0, 32'h0,         32'hCAFE_F00D, 4, 32'hCAFE_F00D, 1, 4'hF, 32'h0);
    tbl[2]  = mk(32'h0800_0000, 2'd2, 1, 0, 0, 32'h0,         32'h1234_5678, 6, 32'h1234_5678, 1, 4'hF, 32'h0);
    tbl[3]  = mk(32'h0800_0004, 2'd2, 1, 0, 1, 32'h0,         32'h9ABC_DEF0, 4, 32'h9ABC_DEF0, 1, 4'hF, 32'h0);
    tbl[4]  = mk(32'h0300_0003, 2'd0, 0, 1, 0, 32'hFFFF_FFAB, 32'h0,         2, 32'h0,         1, 4'h8, 32'hABAB_ABAB);
    tbl[5]  = mk(32'h0300_0001, 2'd2, 1, 0, 0, 32'h0,         32'hAABB_CCDD, 2, 32'hDDAA_BBCC, 1, 4'hF, 32'h0);
    tbl[6]  = mk(32'h0300_0002, 2'd1, 1, 0, 0, 32'h0,         32'hAABB_CCDD, 2, 32'h0000_AABB, 1, 4'hC, 32'h0);
    tbl[7]  = mk(32'h0300_0002, 2'd0, 1, 0, 0, 32'h0,         32'hAABB_CCDD, 2, 32'h0000_00BB, 1, 4'h4, 32'h0);
    tbl[8]  = mk(32'h0300_0001, 2'd1, 0, 1, 0, 32'h1234_5678, 32'h0,         2, 32'h0,         1, 4'h3, 32'h5678_5678);
    tbl[9]  = mk(32'h0100_0000, 2'd2, 1, 0, 0, 32'h0,         32'h0,         2, 32'h0,         0, 4'h0, 32'h0);
    tbl[10] = mk(32'h0000_0004, 2'd3, 1, 0, 0, 32'h0,         32'h0BAD_BEEF, 2, 32'h0BAD_BEEF, 1, 4'hF, 32'h0);
    tbl[11] = mk(32'h0400_0000, 2'd2, 1, 1, 0, 32'h55AA_55AA, 32'h0,         2, 32'h0,         1, 4'hF, 32'h55AA_55AA);
    tbl[12] = mk(32'h0E00_0000, 2'd2, 0, 1, 0, 32'h1,         32'h0,         2, 32'h0,         0, 4'h0, 32'h0);
    tbl[13] = mk(32'h0D00_0003, 2'd2, 1, 0, 0, 32'h0,         32'h1122_3344, 6, 32'h2233_4411, 1, 4'hF, 32'h0);

    rst_n = 1'b0; req_read_en = 0; req_write_en = 0; req_seq = 0;
    req_addr = 0; req_wdata = 0; req_size = 0;
    repeat (3) @(posedge clk);
    #2;
    chk("rst_cpu_wait", 32'(cpu_wait), 32'd0);
    chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("rst_mem_en", 32'(mem_en), 32'd0);
    chk("rst_mem_we", 32'(mem_we), 32'd0);
    chk("rst_mem_be", 32'(mem_be), 32'd0);
    chk("rst_rsp_rdata", rsp_rdata, 32'd0);
    chk("rst_mem_addr", mem_addr, 32'd0);
    chk("rst_mem_wdata", mem_wdata, 32'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Back-to-back transactions: each new request follows the RESP edge.
    foreach (tbl[i]) run(tbl[i]);
    req_read_en = 0; req_write_en = 0; req_seq = 0;
    repeat (2) @(posedge clk); #1;

    // Abort an EWRAM read in WAIT with reset.
    req_addr = 32'h0200_0000; req_size = 2'd2; req_read_en = 1; req_write_en = 0;
    cur_store = 32'hDEAD_0001;
    @(negedge clk);
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    rq.delete(); mq.delete(); last_rd = 32'd0;
    chk("abort_cpu_wait", 32'(cpu_wait), 32'd0);
    chk("abort_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("abort_mem_en", 32'(mem_en), 32'd0);
    chk("abort_mem_be", 32'(mem_be), 32'd0);
    chk("abort_rsp_rdata", rsp_rdata, 32'd0);
    chk("abort_mem_addr", mem_addr, 32'd0);
    @(negedge clk);
    req_read_en = 0;
    repeat (2) @(posedge clk);
    #3 rst_n = 1'b1;
    repeat (8) @(negedge clk);
    @(posedge clk); #1;

    // Recovery after reset.
    run(tbl[0]);
    req_read_en = 0; req_write_en = 0;
    repeat (3) @(posedge clk);
    chk("rsp_left", 32'(rq.size()), 32'd0);
    chk("mem_left", 32'(mq.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
